// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB register-bank completer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package apb_slave_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_st_t;

  // Word index that selects the read-only status register (offset 0x3FF_FFFC).
  localparam logic [23:0] STATUS_IDX = 24'hFF_FFFF;
  localparam int          OFFSET_MSB = 25;
  localparam int          DATA_W     = 32;

endpackage

// File: rtl/apb_slave_wordmem.sv
// DEPTH x 32 word store: synchronous write port, combinational read port, no reset.
// Latency: write visible on the edge after we; read is same-cycle combinational.
// Backpressure: none; the caller decides when to write.
module apb_slave_wordmem
  import apb_slave_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  // Kept as a plain array so it can be swapped for an SRAM macro later.
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Commit one word per enabled edge; contents are undefined until written.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_slave_regbank.sv
// APB completer: word storage, read-only transfer-count status word, Pslverr decode.
// Latency: setup cycle + (WAIT_STATES + 1) access cycles per transfer.
// Backpressure: Pready held low for WAIT_STATES access cycles; Psel drop aborts.
module apb_slave_regbank
  import apb_slave_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  parameter int CNT_W       = 16
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr
);

  localparam int AW = $clog2(DEPTH);

  apb_st_t           r_state;
  apb_st_t           w_state_nxt;
  logic [3:0]        r_wait_cnt;
  logic [AW-1:0]     r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;
  logic [DATA_W-1:0] r_rd;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic [CNT_W-1:0]  r_rd_cnt;

  logic              w_setup;
  logic              w_done;
  logic              w_pready;
  logic [23:0]       w_idx;
  logic              w_in_range;
  logic              w_is_status;
  logic              w_err;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_mem_rdata;
  logic [DATA_W-1:0] w_rd_sel;
  logic              w_mem_we;
  logic              w_unused;

  // Address bits outside the 64 MB per-slave window are not decoded.
  assign w_unused = ^{Paddr[31:OFFSET_MSB+1], Paddr[1:0]};

  assign w_idx       = Paddr[OFFSET_MSB:2];
  assign w_in_range  = (32'(w_idx) < 32'(DEPTH));
  assign w_is_status = (w_idx == STATUS_IDX);
  // Status is read-only, so only a write to it is an error; unmapped is always an error.
  assign w_err       = w_is_status ? Pwrite : ~w_in_range;
  assign w_status    = 32'({r_wr_cnt, r_rd_cnt});
  assign w_rd_sel    = w_is_status ? w_status : (w_in_range ? w_mem_rdata : '0);

  // Next-state and completion decode; setup in ACCESS is abort + fresh setup.
  always_comb begin
    w_state_nxt = r_state;
    w_setup     = 1'b0;
    w_done      = 1'b0;
    w_pready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Psel && !Penable) begin
          w_setup     = 1'b1;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_pready = (r_wait_cnt == 4'd0) && Psel && Penable;
        if (Psel && !Penable) begin
          w_setup     = 1'b1;
          w_state_nxt = ST_ACCESS;
        end else if (!Psel) begin
          w_state_nxt = ST_IDLE;
        end else if (w_pready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Setup-phase capture of the request and pre-fetched read data; wait-state countdown.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      r_wait_cnt <= 4'd0;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
      r_rd       <= '0;
    end else if (w_setup) begin
      r_wait_cnt <= 4'(WAIT_STATES);
      r_addr     <= Paddr[AW+1:2];
      r_write    <= Pwrite;
      r_wdata    <= Pwdata;
      r_err      <= w_err;
      r_rd       <= w_rd_sel;
    end else if ((r_state == ST_ACCESS) && Psel && Penable && (r_wait_cnt != 4'd0)) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  // Saturating counts of error-free completed transfers.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else if (w_done && !r_err) begin
      if (r_write) begin
        if (r_wr_cnt != {CNT_W{1'b1}}) begin
          r_wr_cnt <= r_wr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        if (r_rd_cnt != {CNT_W{1'b1}}) begin
          r_rd_cnt <= r_rd_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign w_mem_we = w_done & r_write & ~r_err;

  apb_slave_wordmem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (Hclk),
    .i_we    (w_mem_we),
    .i_waddr (r_addr),
    .i_wdata (r_wdata),
    .i_raddr (Paddr[AW+1:2]),
    .o_rdata (w_mem_rdata)
  );

  assign Pready  = w_pready;
  assign Pslverr = w_pready & r_err;
  assign Prdata  = (w_pready && !r_write && !r_err) ? r_rd : '0;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench: three completers (0, 3, 5 wait states) on one shared APB bus.
// Expected responses are queued when a transfer is issued and checked at completion.
module tb_apb_slave_regbank;
  import apb_slave_pkg::*;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic [2:0]  psel;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          ws;
  } exp_t;

  exp_t sb_q[$];

  always #5 Hclk = ~Hclk;

  apb_slave_regbank #(.DEPTH(256), .WAIT_STATES(0), .CNT_W(16)) u_dut0 (
    .Hclk(Hclk), .Hreset(Hreset), .Psel(psel[0]), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata[0]), .Pready(pready[0]), .Pslverr(pslverr[0])
  );

  apb_slave_regbank #(.DEPTH(256), .WAIT_STATES(3), .CNT_W(16)) u_dut3 (
    .Hclk(Hclk), .Hreset(Hreset), .Psel(psel[1]), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata[1]), .Pready(pready[1]), .Pslverr(pslverr[1])
  );

  apb_slave_regbank #(.DEPTH(256), .WAIT_STATES(5), .CNT_W(16)) u_dut5 (
    .Hclk(Hclk), .Hreset(Hreset), .Psel(psel[2]), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata[2]), .Pready(pready[2]), .Pslverr(pslverr[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; leaves the bus idle at posedge+1 after the completion edge,
  // so consecutive calls produce back-to-back transfers.
  task automatic xfer(input string tag, input int s, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic exp_err, input logic [31:0] exp_rd, input int exp_ws);
    exp_t e;
    exp_t q;
    int   waits;
    bit   done;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.ws    = exp_ws;
    sb_q.push_back(e);
    psel    = 3'(1 << s);
    Penable = 1'b0;
    Pwrite  = wr;
    Paddr   = addr;
    Pwdata  = wd;
    @(posedge Hclk); #1;
    Penable = 1'b1;
    waits = 0;
    done  = 1'b0;
    for (int c = 0; c < 32 && !done; c++) begin
      @(negedge Hclk);
      if (pready[s]) begin
        done = 1'b1;
      end else begin
        chk({tag, "_wait_prdata"}, prdata[s], 32'h0);
        waits++;
        @(posedge Hclk); #1;
      end
    end
    q = sb_q.pop_front();
    chk({tag, "_completed"}, {31'd0, done}, 32'd1);
    if (done) begin
      chk({tag, "_waits"}, 32'(waits), 32'(q.ws));
      chk({tag, "_prdata"}, prdata[s], q.rdata);
      chk({tag, "_pslverr"}, {31'd0, pslverr[s]}, {31'd0, q.err});
      @(posedge Hclk); #1;
    end
    psel    = 3'b000;
    Penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    Hreset  = 1'b1;
    psel    = 3'b000;
    Penable = 1'b0;
    Pwrite  = 1'b0;
    Paddr   = 32'h0;
    Pwdata  = 32'h0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_pready",  {31'd0, pready[i]},  32'h0);
      chk("rst_prdata",  prdata[i],           32'h0);
      chk("rst_pslverr", {31'd0, pslverr[i]}, 32'h0);
    end
    @(posedge Hclk); #1;
    Hreset = 1'b0;
    @(posedge Hclk); #1;

    // Penable without a setup phase is ignored.
    psel = 3'b001; Penable = 1'b1; Pwrite = 1'b0; Paddr = 32'h8000_0010;
    @(negedge Hclk);
    chk("noset_pready", {31'd0, pready[0]}, 32'h0);
    @(posedge Hclk); #1;
    chk("noset_state", 32'(u_dut0.r_state), 32'(ST_IDLE));
    psel = 3'b000; Penable = 1'b0;

    // Zero-wait write/read, then status counting (2 writes, 1 read).
    xfer("t1_wr",    0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         0);
    xfer("t1_rd",    0, 1'b0, 32'h8000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 0);
    xfer("t4_wr2",   0, 1'b1, 32'h8000_0014, 32'hCAFE_F00D, 1'b0, 32'h0,         0);
    xfer("t4_st1",   0, 1'b0, 32'h83FF_FFFC, 32'h0,         1'b0, 32'h0002_0001, 0);
    xfer("t4_st_wr", 0, 1'b1, 32'h83FF_FFFC, 32'hFFFF_FFFF, 1'b1, 32'h0,         0);
    xfer("t4_st2",   0, 1'b0, 32'h83FF_FFFC, 32'h0,         1'b0, 32'h0002_0002, 0);

    // Out-of-range index 256: error, no storage or counter effect.
    xfer("t3_wr0",   0, 1'b1, 32'h8000_0000, 32'h0000_AAAA, 1'b0, 32'h0,         0);
    xfer("t3_oor_w", 0, 1'b1, 32'h8000_0400, 32'h1234_5678, 1'b1, 32'h0,         0);
    xfer("t3_rd0",   0, 1'b0, 32'h8000_0000, 32'h0,         1'b0, 32'h0000_AAAA, 0);
    xfer("t3_oor_r", 0, 1'b0, 32'h8000_0400, 32'h0,         1'b1, 32'h0,         0);
    xfer("t3_st",    0, 1'b0, 32'h83FF_FFFC, 32'h0,         1'b0, 32'h0003_0004, 0);

    // Three wait states.
    xfer("t2_wr",    1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         3);
    xfer("t2_rd",    1, 1'b0, 32'h8000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 3);

    // Five wait states with an abort after two access cycles.
    xfer("t5_init",  2, 1'b1, 32'h8000_0010, 32'h1111_1111, 1'b0, 32'h0,         5);
    psel = 3'b100; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h8000_0010; Pwdata = 32'hA5A5_A5A5;
    @(posedge Hclk); #1;
    Penable = 1'b1;
    repeat (2) begin
      @(negedge Hclk);
      chk("t5_pready_low", {31'd0, pready[2]}, 32'h0);
      @(posedge Hclk); #1;
    end
    psel = 3'b000; Penable = 1'b0;
    @(posedge Hclk); #1;
    chk("t5_idle", 32'(u_dut5.r_state), 32'(ST_IDLE));
    xfer("t5_rd",    2, 1'b0, 32'h8000_0010, 32'h0,         1'b0, 32'h1111_1111, 5);
    xfer("t5_st",    2, 1'b0, 32'h83FF_FFFC, 32'h0,         1'b0, 32'h0001_0001, 5);

    // Asynchronous reset in the middle of a completing access.
    psel = 3'b001; Penable = 1'b0; Pwrite = 1'b0; Paddr = 32'h8000_0010;
    @(posedge Hclk); #1;
    Penable = 1'b1;
    #2;
    chk("t6_pre_pready", {31'd0, pready[0]}, 32'h1);
    chk("t6_pre_prdata", prdata[0], 32'hDEAD_BEEF);
    Hreset = 1'b1;
    #1;
    chk("t6_pready",  {31'd0, pready[0]},  32'h0);
    chk("t6_prdata",  prdata[0],           32'h0);
    chk("t6_pslverr", {31'd0, pslverr[0]}, 32'h0);
    psel = 3'b000; Penable = 1'b0;
    @(posedge Hclk); #1;
    Hreset = 1'b0;
    @(posedge Hclk); #1;
    xfer("t6_st0",   0, 1'b0, 32'h83FF_FFFC, 32'h0,         1'b0, 32'h0,         0);
    xfer("t6_st5",   2, 1'b0, 32'h83FF_FFFC, 32'h0,         1'b0, 32'h0,         5);

    chk("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
